// File: rtl/vga_scan_out_if.sv
// Frame-buffer read port between the VGA scan-out stage (master) and the
// grayscale frame buffer (slave).
//
// Read protocol: there is no back-pressure. Every clk25 cycle the master
// presents rd_addr. rd_en marks that address as a visible pixel. The slave
// returns rd_data for that address exactly RD_LAT cycles later,
// unconditionally. When rd_en is low, rd_addr is don't-care and the
// returned data is ignored.
interface vga_scan_out_if;
    logic [18:0] rd_addr;
    logic        rd_en;
    logic [3:0]  rd_data;

    modport master (output rd_addr, output rd_en, input rd_data);
    modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_scan_out.sv
// VGA scan-out: raster counters, frame-buffer read addressing and a fixed
// RD_LAT+1 output pipeline, so that sync, colour and frame_start leave on
// the same cycle as the pixel they belong to.
module vga_scan_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                  clk25,
    input  logic                  rst_n,
    input  logic                  en,
    vga_scan_out_if.master        fb,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    // Tag bit positions carried through the read-latency delay line
    localparam int T_EN    = 0;
    localparam int T_ACT   = 1;
    localparam int T_HS    = 2;
    localparam int T_VS    = 3;
    localparam int T_FIRST = 4;

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic [18:0]    pix_idx;
    logic           en_frame;

    logic           active;
    logic           hs_raw;
    logic           vs_raw;
    logic           first_pix;
    logic           frame_last;
    logic [4:0]     tag_now;
    logic [4:0]     tag_d;
    logic [4:0]     pipe [RD_LAT];

    // Decode the raster position into visibility, raw sync and frame markers
    always_comb begin
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_raw     = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_raw     = (v_cnt >= VS_START) && (v_cnt < VS_END);
        first_pix  = (h_cnt == '0) && (v_cnt == '0);
        frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        tag_now    = '0;
        tag_now[T_EN]    = en_frame;
        tag_now[T_ACT]   = active;
        tag_now[T_HS]    = hs_raw;
        tag_now[T_VS]    = vs_raw;
        tag_now[T_FIRST] = first_pix;
        tag_d      = pipe[RD_LAT-1];
    end

    // The read is issued combinationally from the counters; rd_en is held
    // low during reset even though the counters then sit on pixel (0,0)
    assign fb.rd_addr = pix_idx;
    assign fb.rd_en   = active & rst_n;

    // Horizontal and vertical raster counters
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Linear pixel index: advances on visible pixels only, so it stays equal
    // to v*H_ACTIVE+h without needing a multiplier
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            pix_idx <= '0;
        end else if (frame_last) begin
            pix_idx <= '0;
        end else if (active) begin
            pix_idx <= pix_idx + 19'd1;
        end
    end

    // Enable is latched only at the frame boundary, so frames are never torn
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            en_frame <= 1'b0;
        end else if (frame_last) begin
            en_frame <= en;
        end
    end

    // Delay the per-pixel tags by the frame-buffer read latency
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_now;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Output register: combine the delayed tags with the returned pixel
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= 4'h0;
            vga_g       <= 4'h0;
            vga_b       <= 4'h0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= (tag_d[T_ACT] && tag_d[T_EN]) ? fb.rd_data : 4'h0;
            vga_g       <= (tag_d[T_ACT] && tag_d[T_EN]) ? fb.rd_data : 4'h0;
            vga_b       <= (tag_d[T_ACT] && tag_d[T_EN]) ? fb.rd_data : 4'h0;
            vga_hs      <= tag_d[T_HS] ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= tag_d[T_VS] ? SYNC_POL : ~SYNC_POL;
            frame_start <= tag_d[T_FIRST];
        end
    end
endmodule
